// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar types: read-arbiter states, latched AR request and slave-ID
// composition width.
package axi_xbar_pkg;

  localparam int MIDX_BITS    = 4;
  localparam int XB_ID_BITS   = 4;
  localparam int XB_ADDR_BITS = 32;
  localparam int XB_LEN_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } rd_arb_state_e;

  typedef struct packed {
    logic [XB_ID_BITS-1:0]   id;
    logic [XB_ADDR_BITS-1:0] addr;
    logic [XB_LEN_BITS-1:0]  len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_req_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester after last_grant wins.
// Purely combinational, no state and no backpressure.
module rr_picker #(
  parameter int NUM_M = 2,
  parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NUM_M-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      k = (int'(last_grant) + i) % NUM_M;
      if (!gnt_vld && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_port_arbiter.sv
// Per-slave AXI read arbiter: round-robin AR grant, one burst in flight, R steered to owner.
// Master AR accepted same cycle, slave AR one cycle later; R backpressure passes straight through.
module axi_rd_port_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4
) (
  input  logic                       AXI_CLK_i,
  input  logic                       AXI_RST_i,
  input  logic [NUM_M-1:0]           ARVALID_M_i,
  input  logic [NUM_M*ID_BITS-1:0]   ARID_M_i,
  input  logic [NUM_M*ADDR_BITS-1:0] ARADDR_M_i,
  input  logic [NUM_M*LEN_BITS-1:0]  ARLEN_M_i,
  input  logic [NUM_M*3-1:0]         ARSIZE_M_i,
  input  logic [NUM_M*2-1:0]         ARBURST_M_i,
  output logic [NUM_M-1:0]           ARREADY_M_o,
  output logic [NUM_M-1:0]           RVALID_M_o,
  input  logic [NUM_M-1:0]           RREADY_M_i,
  output logic [ID_BITS-1:0]         RID_M_o,
  output logic [DATA_BITS-1:0]       RDATA_M_o,
  output logic [1:0]                 RRESP_M_o,
  output logic                       RLAST_M_o,
  output logic [IDS_BITS-1:0]        ARID_S_o,
  output logic [ADDR_BITS-1:0]       ARADDR_S_o,
  output logic [LEN_BITS-1:0]        ARLEN_S_o,
  output logic [2:0]                 ARSIZE_S_o,
  output logic [1:0]                 ARBURST_S_o,
  output logic                       ARVALID_S_o,
  input  logic                       ARREADY_S_i,
  input  logic [IDS_BITS-1:0]        RID_S_i,
  input  logic [DATA_BITS-1:0]       RDATA_S_i,
  input  logic [1:0]                 RRESP_S_i,
  input  logic                       RLAST_S_i,
  input  logic                       RVALID_S_i,
  output logic                       RREADY_S_o,
  output logic [NUM_M-1:0]           grant_o,
  output logic                       busy_o,
  output logic                       len_err_o
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  rd_arb_state_e         state;
  ar_req_t               req_q;
  ar_req_t               pick_req;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      cur_idx;
  logic [LEN_BITS-1:0]   beats_left;
  logic [NUM_M-1:0]      grant_q;
  logic                  len_err_q;
  logic [NUM_M-1:0]      pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic                  in_r;
  logic                  r_hs;
  int                    sel;

  rr_picker #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_rr_picker (
    .req        (ARVALID_M_i),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .gnt_idx    (pick_idx),
    .gnt_vld    (pick_vld)
  );

  always_comb begin
    sel            = int'(pick_idx);
    pick_req.id    = ARID_M_i[sel*ID_BITS +: ID_BITS];
    pick_req.addr  = ARADDR_M_i[sel*ADDR_BITS +: ADDR_BITS];
    pick_req.len   = ARLEN_M_i[sel*LEN_BITS +: LEN_BITS];
    pick_req.size  = ARSIZE_M_i[sel*3 +: 3];
    pick_req.burst = ARBURST_M_i[sel*2 +: 2];
  end

  assign in_r = (state == R);
  assign r_hs = in_r && RVALID_S_i && RREADY_S_o;

  // Reset gates the combinational accept so every output reads 0 while held in reset.
  assign ARREADY_M_o = (AXI_RST_i && state == IDLE) ? pick_gnt : '0;

  assign ARVALID_S_o = (state == AR);
  assign ARID_S_o    = {MIDX_BITS'(cur_idx), req_q.id};
  assign ARADDR_S_o  = req_q.addr;
  assign ARLEN_S_o   = req_q.len;
  assign ARSIZE_S_o  = req_q.size;
  assign ARBURST_S_o = req_q.burst;

  assign RVALID_M_o  = (in_r && RVALID_S_i) ? grant_q : '0;
  assign RREADY_S_o  = in_r && |(RREADY_M_i & grant_q);
  assign RID_M_o     = in_r ? RID_S_i[ID_BITS-1:0] : '0;
  assign RDATA_M_o   = in_r ? RDATA_S_i : '0;
  assign RRESP_M_o   = in_r ? RRESP_S_i : '0;
  assign RLAST_M_o   = in_r && RLAST_S_i;

  assign grant_o   = grant_q;
  assign busy_o    = (state != IDLE);
  assign len_err_o = len_err_q;

  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) begin
      state      <= IDLE;
      req_q      <= '0;
      last_grant <= IDX_W'(NUM_M - 1);
      cur_idx    <= '0;
      beats_left <= '0;
      grant_q    <= '0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            req_q   <= pick_req;
            cur_idx <= pick_idx;
            grant_q <= pick_gnt;
            state   <= AR;
          end
        end
        AR: begin
          if (ARREADY_S_i) begin
            beats_left <= req_q.len;
            state      <= R;
          end
        end
        R: begin
          if (r_hs) begin
            if (beats_left != '0) beats_left <= beats_left - 1'b1;
            // Burst ends only on RLAST; a count overrun is flagged but not enforced.
            if (RLAST_S_i) begin
              state      <= IDLE;
              last_grant <= cur_idx;
              grant_q    <= '0;
              len_err_q  <= (beats_left != '0);
            end else if (beats_left == '0) begin
              len_err_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_port_arbiter.sv
// Scoreboard bench for axi_rd_port_arbiter: directed bursts, behavioural slave, decoupled monitor.
module tb_axi_rd_port_arbiter;

  localparam int NUM_M = 2, ID_BITS = 4, IDS_BITS = 8, ADDR_BITS = 32, DATA_BITS = 32, LEN_BITS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_M-1:0]           arvalid_m = '0;
  logic [NUM_M*ID_BITS-1:0]   arid_m    = '0;
  logic [NUM_M*ADDR_BITS-1:0] araddr_m  = '0;
  logic [NUM_M*LEN_BITS-1:0]  arlen_m   = '0;
  logic [NUM_M*3-1:0]         arsize_m  = '0;
  logic [NUM_M*2-1:0]         arburst_m = '0;
  logic [NUM_M-1:0]           rready_m  = '1;
  logic                       arready_s = 1'b0;
  logic [IDS_BITS-1:0]        rid_s     = '0;
  logic [DATA_BITS-1:0]       rdata_s   = '0;
  logic [1:0]                 rresp_s   = '0;
  logic                       rlast_s   = 1'b0;
  logic                       rvalid_s  = 1'b0;

  logic [NUM_M-1:0]     ARREADY_M_o, RVALID_M_o, grant_o;
  logic [ID_BITS-1:0]   RID_M_o;
  logic [DATA_BITS-1:0] RDATA_M_o;
  logic [1:0]           RRESP_M_o, ARBURST_S_o;
  logic                 RLAST_M_o, ARVALID_S_o, RREADY_S_o, busy_o, len_err_o;
  logic [IDS_BITS-1:0]  ARID_S_o;
  logic [ADDR_BITS-1:0] ARADDR_S_o;
  logic [LEN_BITS-1:0]  ARLEN_S_o;
  logic [2:0]           ARSIZE_S_o;

  axi_rd_port_arbiter #(
    .NUM_M(NUM_M), .ID_BITS(ID_BITS), .IDS_BITS(IDS_BITS),
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)
  ) dut (
    .AXI_CLK_i(clk), .AXI_RST_i(rst_n),
    .ARVALID_M_i(arvalid_m), .ARID_M_i(arid_m), .ARADDR_M_i(araddr_m),
    .ARLEN_M_i(arlen_m), .ARSIZE_M_i(arsize_m), .ARBURST_M_i(arburst_m),
    .ARREADY_M_o(ARREADY_M_o), .RVALID_M_o(RVALID_M_o), .RREADY_M_i(rready_m),
    .RID_M_o(RID_M_o), .RDATA_M_o(RDATA_M_o), .RRESP_M_o(RRESP_M_o), .RLAST_M_o(RLAST_M_o),
    .ARID_S_o(ARID_S_o), .ARADDR_S_o(ARADDR_S_o), .ARLEN_S_o(ARLEN_S_o),
    .ARSIZE_S_o(ARSIZE_S_o), .ARBURST_S_o(ARBURST_S_o), .ARVALID_S_o(ARVALID_S_o),
    .ARREADY_S_i(arready_s), .RID_S_i(rid_s), .RDATA_S_i(rdata_s), .RRESP_S_i(rresp_s),
    .RLAST_S_i(rlast_s), .RVALID_S_i(rvalid_s), .RREADY_S_o(RREADY_S_o),
    .grant_o(grant_o), .busy_o(busy_o), .len_err_o(len_err_o)
  );

  typedef struct {
    int          m;
    logic [7:0]  arid;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_exp_t;

  typedef struct {
    int          m;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int checks = 0, failures = 0;
  int err_seen = 0, err_exp = 0;
  int ar_delay = 0, force_beats = 0, cyc = 0;
  bit rr_toggle = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_burst(input int m, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input int nb);
    ar_exp_t a;
    r_exp_t  r;
    a.m = m; a.arid = {4'(m), id}; a.addr = addr; a.len = len; a.size = 3'(m + 1); a.burst = 2'b01;
    ar_q.push_back(a);
    for (int i = 0; i < nb; i++) begin
      r.m = m; r.id = id; r.data = addr + 32'(4 * i); r.resp = 2'(i); r.last = (i == nb - 1);
      r_q.push_back(r);
    end
  endtask

  task automatic m_issue(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int g;
    g = 0;
    arid_m[m*ID_BITS +: ID_BITS]       = id;
    araddr_m[m*ADDR_BITS +: ADDR_BITS] = addr;
    arlen_m[m*LEN_BITS +: LEN_BITS]    = len;
    arsize_m[m*3 +: 3]                 = 3'(m + 1);
    arburst_m[m*2 +: 2]                = 2'b01;
    arvalid_m[m]                       = 1'b1;
    @(negedge clk);
    while (!ARREADY_M_o[m] && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (!ARREADY_M_o[m]) chk("ar_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid_m[m] = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while ((ar_q.size() != 0 || r_q.size() != 0 || busy_o) && g < 1000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 1000) chk("burst_done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("len_err_pulses", 64'(err_seen), 64'(err_exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_side"}, 64'({ARREADY_M_o, RVALID_M_o, RID_M_o, RDATA_M_o, RRESP_M_o, RLAST_M_o}), 64'd0);
    chk({tag, "_s_side"}, 64'({ARID_S_o, ARADDR_S_o, ARLEN_S_o, ARSIZE_S_o, ARBURST_S_o,
                               ARVALID_S_o, RREADY_S_o, grant_o, busy_o, len_err_o}), 64'd0);
  endtask

  // Behavioural slave: programmable AR stall, returns addr+4*i, RID upper nibble scrambled.
  initial begin
    int phase, wcnt, nb, bi;
    logic [7:0]  c_id;
    logic [31:0] c_addr;
    logic [3:0]  c_len;
    logic a_hs, r_hs;
    phase = 0; wcnt = 0; nb = 0; bi = 0; c_id = '0; c_addr = '0; c_len = '0;
    forever begin
      @(negedge clk);
      a_hs = ARVALID_S_o && arready_s;
      r_hs = rvalid_s && RREADY_S_o;
      if (a_hs) begin
        c_id = ARID_S_o; c_addr = ARADDR_S_o; c_len = ARLEN_S_o;
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        phase = 0; wcnt = 0; arready_s = 1'b0; rvalid_s = 1'b0; rlast_s = 1'b0;
      end else if (phase == 0) begin
        if (a_hs) begin
          arready_s = 1'b0; wcnt = 0; bi = 0; phase = 1;
          nb = (force_beats > 0) ? force_beats : int'(c_len) + 1;
        end else if (ARVALID_S_o) begin
          arready_s = (wcnt >= ar_delay);
          wcnt++;
        end
      end else if (r_hs) begin
        bi++;
        if (bi == nb) begin
          rvalid_s = 1'b0; rlast_s = 1'b0; phase = 0;
        end
      end
      if (rst_n && phase == 1) begin
        rvalid_s = 1'b1;
        rdata_s  = c_addr + 32'(4 * bi);
        rresp_s  = 2'(bi);
        rlast_s  = (bi == nb - 1);
        rid_s    = {c_id[7:4] ^ 4'hA, c_id[3:0]};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      rready_m[0] = 1'b1;
      rready_m[1] = rr_toggle ? (cyc % 3 != 0) : 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake.
  initial begin
    int  cur_m;
    bit  ar_hs_prev;
    ar_exp_t a;
    r_exp_t  r;
    cur_m = 0; ar_hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_hs_prev = 1'b0;
      end else begin
        if (ar_hs_prev) chk("ar_slave_latency", 64'(ARVALID_S_o), 64'd1);
        ar_hs_prev = |(arvalid_m & ARREADY_M_o);
        if (ARVALID_S_o) begin
          if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
          else begin
            a = ar_q[0];
            chk("arid_s", 64'(ARID_S_o), 64'(a.arid));
            chk("araddr_s", 64'(ARADDR_S_o), 64'(a.addr));
            chk("arlen_s", 64'(ARLEN_S_o), 64'(a.len));
            chk("arsize_s", 64'(ARSIZE_S_o), 64'(a.size));
            chk("arburst_s", 64'(ARBURST_S_o), 64'(a.burst));
            chk("grant", 64'(grant_o), 64'(1 << a.m));
            if (arready_s) begin
              cur_m = a.m;
              void'(ar_q.pop_front());
            end
          end
        end
        if (busy_o) chk("no_accept_while_busy", 64'(ARREADY_M_o), 64'd0);
        if (busy_o && !ARVALID_S_o) begin
          chk("rvalid_route", 64'(RVALID_M_o), rvalid_s ? 64'(1 << cur_m) : 64'd0);
          chk("rready_s_follow", 64'(RREADY_S_o), 64'(rready_m[cur_m]));
        end
        for (int m = 0; m < NUM_M; m++) begin
          if (RVALID_M_o[m] && rready_m[m]) begin
            if (r_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
            else begin
              r = r_q.pop_front();
              chk("r_master", 64'(m), 64'(r.m));
              chk("rid_m", 64'(RID_M_o), 64'(r.id));
              chk("rdata_m", 64'(RDATA_M_o), 64'(r.data));
              chk("rresp_m", 64'(RRESP_M_o), 64'(r.resp));
              chk("rlast_m", 64'(RLAST_M_o), 64'(r.last));
            end
          end
        end
        if (len_err_o) err_seen++;
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int g;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single M0 burst, LEN=3
    expect_burst(0, 4'h3, 32'h0000_1000, 4'd3, 4);
    m_issue(0, 4'h3, 32'h0000_1000, 4'd3);
    wait_done();

    // Slave AR stalled 5 cycles while M1 is also requesting
    ar_delay = 5;
    expect_burst(0, 4'h6, 32'h0000_3000, 4'd2, 3);
    expect_burst(1, 4'h7, 32'h0000_3400, 4'd1, 2);
    fork
      m_issue(0, 4'h6, 32'h0000_3000, 4'd2);
      begin
        repeat (2) @(posedge clk);
        #1;
        m_issue(1, 4'h7, 32'h0000_3400, 4'd1);
      end
    join
    wait_done();
    ar_delay = 0;

    // M1 burst with RREADY throttled
    rr_toggle = 1'b1;
    expect_burst(1, 4'h5, 32'h0000_2000, 4'd5, 6);
    m_issue(1, 4'h5, 32'h0000_2000, 4'd5);
    wait_done();
    rr_toggle = 1'b0;

    // Two rounds of simultaneous requests: M0, M1, M0, M1
    expect_burst(0, 4'h1, 32'h0000_4000, 4'd1, 2);
    expect_burst(1, 4'h2, 32'h0000_4100, 4'd2, 3);
    fork
      m_issue(0, 4'h1, 32'h0000_4000, 4'd1);
      m_issue(1, 4'h2, 32'h0000_4100, 4'd2);
    join
    wait_done();
    expect_burst(0, 4'h4, 32'h0000_4200, 4'd0, 1);
    expect_burst(1, 4'hE, 32'h0000_4300, 4'd1, 2);
    fork
      m_issue(0, 4'h4, 32'h0000_4200, 4'd0);
      m_issue(1, 4'hE, 32'h0000_4300, 4'd1);
    join
    wait_done();

    // Early RLAST: LEN=3, RLAST on beat 2
    force_beats = 2; err_exp++;
    expect_burst(0, 4'h8, 32'h0000_5000, 4'd3, 2);
    m_issue(0, 4'h8, 32'h0000_5000, 4'd3);
    wait_done();

    // LEN=0 single beat: no error
    force_beats = 0;
    expect_burst(1, 4'h9, 32'h0000_5100, 4'd0, 1);
    m_issue(1, 4'h9, 32'h0000_5100, 4'd0);
    wait_done();

    // Overrun: LEN=1, three beats, one error on the non-last extra beat
    force_beats = 3; err_exp++;
    expect_burst(0, 4'hC, 32'h0000_5200, 4'd1, 3);
    m_issue(0, 4'hC, 32'h0000_5200, 4'd1);
    wait_done();
    force_beats = 0;

    // Reset during R phase of an M0 burst
    expect_burst(0, 4'hD, 32'h0000_6000, 4'd7, 8);
    m_issue(0, 4'hD, 32'h0000_6000, 4'd7);
    g = 0;
    while (r_q.size() > 5 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("reset_burst_progress", 64'(r_q.size() <= 5), 64'd1);
    arvalid_m[1] = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_burst_reset");
    r_q.delete();
    ar_q.delete();
    arvalid_m[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // After reset M0 must win first even though it was last granted
    expect_burst(0, 4'hA, 32'h0000_7000, 4'd1, 2);
    expect_burst(1, 4'hB, 32'h0000_7100, 4'd0, 1);
    fork
      m_issue(0, 4'hA, 32'h0000_7000, 4'd1);
      m_issue(1, 4'hB, 32'h0000_7100, 4'd0);
    join
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
